// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   EX-stage branch/jump resolution. Selects signed/unsigned compare on the
//   external comparator, decides taken/not-taken, registers the redirect
//   target, runs the fetch redirect handshake and sequences IF/ID and ID/EX
//   flushes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   stall_in                 blocks acceptance of a new branch/jump in IDLE
//   br_valid/br_funct3/br_pc/br_imm   conditional branch in EX
//   jump_valid/jump_target   JAL/JALR in EX (priority over br_valid)
//   breq_flag/brlt_flag      comparator flags; brun_en selects unsigned compare
//   redirect_valid/ready/pc  fetch redirect handshake
//   flush_ifid/flush_idex    pipeline squash controls
//   misalign, illegal_br     one-cycle status pulses
//   busy                     FSM not idle
//   stat_branches/stat_taken branch counters
//
// Build option
//   BRANCH_STATS_EN : when defined, builds saturating branch counters;
//                     otherwise the stat outputs are tied to 0.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            br_valid,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            breq_flag,
    input  logic            brlt_flag,
    output logic            brun_en,
    input  logic            redirect_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            misalign,
    output logic            illegal_br,
    output logic            busy,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REDIRECT = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;

    // FLUSH lasts FLUSH_CYCLES cycles: load N-1, leave when the count hits 0.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [1:0]      flush_cnt_q, flush_cnt_d;
    logic            misalign_q, misalign_d;
    logic            illegal_q, illegal_d;

    logic            br_legal, br_taken, idle_open, accept;
    logic [XLEN-1:0] jmp_tgt, target;

    assign brun_en = (br_funct3[2:1] == 2'b11);

    always_comb begin
        br_legal = (br_funct3[2:1] != 2'b01);
        case (br_funct3)
            3'b000:         br_taken = breq_flag;
            3'b001:         br_taken = !breq_flag;
            3'b100, 3'b110: br_taken = brlt_flag;
            3'b101, 3'b111: br_taken = !brlt_flag;
            default:        br_taken = 1'b0;
        endcase

        jmp_tgt    = jump_target;
        jmp_tgt[0] = 1'b0;
        target     = jump_valid ? jmp_tgt : (br_pc + br_imm);

        // Anything arriving outside IDLE is wrong-path and is being flushed.
        idle_open = (state_q == S_IDLE) && !stall_in;
        accept    = idle_open && (jump_valid || (br_valid && br_taken));
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        flush_cnt_d   = flush_cnt_q;
        misalign_d    = 1'b0;
        illegal_d     = idle_open && br_valid && !br_legal;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    redirect_pc_d = target;
                    misalign_d    = target[1];
                    state_d       = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == 2'd0) state_d = S_IDLE;
                else                     flush_cnt_d = flush_cnt_q - 2'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            redirect_pc_q <= '0;
            flush_cnt_q   <= '0;
            misalign_q    <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            flush_cnt_q   <= flush_cnt_d;
            misalign_q    <= misalign_d;
            illegal_q     <= illegal_d;
        end
    end

    // State-decoded outputs so an async reset clears them in the same cycle.
    assign redirect_valid = (state_q == S_REDIRECT);
    assign flush_idex     = (state_q == S_REDIRECT);
    assign flush_ifid     = (state_q == S_REDIRECT) || (state_q == S_FLUSH);
    assign busy           = (state_q != S_IDLE);
    assign redirect_pc    = redirect_pc_q;
    assign misalign       = misalign_q;
    assign illegal_br     = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_tk_q, stat_tk_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_tk_d = stat_tk_q;
        if (idle_open && br_valid && br_legal && (stat_br_q != 32'hFFFF_FFFF))
            stat_br_d = stat_br_q + 32'd1;
        // A jump wins over a simultaneous branch, so that branch is not taken.
        if (accept && !jump_valid && (stat_tk_q != 32'hFFFF_FFFF))
            stat_tk_d = stat_tk_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_tk_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_tk_q <= stat_tk_d;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_taken    = stat_tk_q;
`else
    assign stat_branches = 32'd0;
    assign stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in, br_valid, jump_valid, breq_flag, brlt_flag, redirect_ready;
    logic [2:0]  br_funct3;
    logic [31:0] br_pc, br_imm, jump_target;
    logic        brun_en, redirect_valid, flush_ifid, flush_idex, misalign, illegal_br, busy;
    logic [31:0] redirect_pc, stat_branches, stat_taken;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .br_valid(br_valid), .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .breq_flag(breq_flag), .brlt_flag(brlt_flag), .brun_en(brun_en),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .misalign(misalign), .illegal_br(illegal_br), .busy(busy),
        .stat_branches(stat_branches), .stat_taken(stat_taken)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        eq;
        logic        lt;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        brun;
        logic        taken;
        logic        ill;
    } vec_t;

    vec_t        tv[13];
    logic [31:0] exp_q[$];
    int          n_run = 0;
    int          n_fail = 0;
    int          exp_br = 0;
    int          exp_tk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] stat_exp(input int v);
`ifdef BRANCH_STATS_EN
        return 32'(v);
`else
        return 32'd0 + 32'(v - v);
`endif
    endfunction

    // Called right after the accept edge; consumes one scoreboard entry.
    task automatic drain(input int hold);
        int          waited = 0;
        logic [31:0] e;
        while (!redirect_valid && waited < 5) begin
            tick();
            waited++;
        end
        if (!redirect_valid || exp_q.size() == 0) begin
            chk("redirect_timeout", {31'd0, redirect_valid}, 32'd1);
            chk("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk("redirect_pc", redirect_pc, e);
        chk("misalign", {31'd0, misalign}, {31'd0, e[1]});
        chk("redir_flush_ifid", {31'd0, flush_ifid}, 32'd1);
        chk("redir_flush_idex", {31'd0, flush_idex}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
            chk("hold_pc", redirect_pc, e);
            chk("hold_flush_idex", {31'd0, flush_idex}, 32'd1);
            chk("misalign_one_cycle", {31'd0, misalign}, 32'd0);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("flush_ifid_only", {31'd0, flush_ifid}, 32'd1);
        chk("flush_idex_off", {31'd0, flush_idex}, 32'd0);
        chk("flush_valid_off", {31'd0, redirect_valid}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_flush_ifid", {31'd0, flush_ifid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{3'b000, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0020, 1'b0, 1'b1, 1'b0};
        tv[1]  = '{3'b000, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0020, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{3'b001, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0040, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{3'b001, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0040, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{3'b100, 1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FF00, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{3'b101, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_0008, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{3'b110, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_0010, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{3'b111, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_0010, 1'b1, 1'b0, 1'b0};
        tv[8]  = '{3'b111, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0024, 1'b1, 1'b1, 1'b0};
        tv[9]  = '{3'b010, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_0010, 1'b0, 1'b0, 1'b1};
        tv[10] = '{3'b011, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_0010, 1'b0, 1'b0, 1'b1};
        tv[11] = '{3'b100, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
        tv[12] = '{3'b000, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0012, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; stall_in = 1'b0; br_valid = 1'b0; jump_valid = 1'b0;
        breq_flag = 1'b0; brlt_flag = 1'b0; redirect_ready = 1'b0;
        br_funct3 = 3'b000; br_pc = '0; br_imm = '0; jump_target = '0;
        #1;
        chk("rst_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {30'd0, misalign, illegal_br}, 32'd0);
        chk("rst_stats", stat_branches | stat_taken, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Decode table: each vector issued from IDLE, unstalled.
        for (int i = 0; i < 13; i++) begin
            br_valid = 1'b1; br_funct3 = tv[i].f3; breq_flag = tv[i].eq;
            brlt_flag = tv[i].lt; br_pc = tv[i].pc; br_imm = tv[i].imm;
            #1;
            chk($sformatf("brun_en[%0d]", i), {31'd0, brun_en}, {31'd0, tv[i].brun});
            if (tv[i].taken) begin
                exp_q.push_back(tv[i].pc + tv[i].imm);
                exp_tk++;
            end
            if (!tv[i].ill) exp_br++;
            tick();
            br_valid = 1'b0;
            chk($sformatf("taken[%0d]", i), {31'd0, redirect_valid}, {31'd0, tv[i].taken});
            chk($sformatf("illegal[%0d]", i), {31'd0, illegal_br}, {31'd0, tv[i].ill});
            if (tv[i].taken) drain(0);
            else begin
                chk($sformatf("nt_busy[%0d]", i), {31'd0, busy}, 32'd0);
                tick();
                chk($sformatf("illegal_pulse_end[%0d]", i), {31'd0, illegal_br}, 32'd0);
            end
        end

        // Handshake hold: ready withheld for 3 cycles.
        br_valid = 1'b1; br_funct3 = 3'b001; breq_flag = 1'b0;
        br_pc = 32'h0000_4000; br_imm = 32'hFFFF_FFFC;
        exp_q.push_back(32'h0000_3FFC); exp_br++; exp_tk++;
        tick();
        br_valid = 1'b0;
        drain(3);

        // Stall blocks acceptance.
        stall_in = 1'b1; br_valid = 1'b1; br_funct3 = 3'b000; breq_flag = 1'b1;
        tick();
        chk("stall_no_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("stall_busy", {31'd0, busy}, 32'd0);
        stall_in = 1'b0; br_valid = 1'b0;
        tick();

        // Jump priority, then a shadow branch during REDIRECT is ignored.
        jump_valid = 1'b1; jump_target = 32'h0000_2001;
        br_valid = 1'b1; br_funct3 = 3'b000; breq_flag = 1'b1;
        br_pc = 32'h0000_0100; br_imm = 32'h0000_0020;
        exp_q.push_back(32'h0000_2000); exp_br++;
        tick();
        jump_valid = 1'b0;
        br_pc = 32'h0000_5000;
        tick();
        br_valid = 1'b0;
        drain(1);
        chk("shadow_ignored_q", 32'(exp_q.size()), 32'd0);
        chk("shadow_no_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("stat_branches", stat_branches, stat_exp(exp_br));
        chk("stat_taken", stat_taken, stat_exp(exp_tk));

        // Reset while in REDIRECT.
        br_valid = 1'b1; br_funct3 = 3'b000; breq_flag = 1'b1;
        br_pc = 32'h0000_0500; br_imm = 32'h0000_0010;
        tick();
        br_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, redirect_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, redirect_valid}, 32'd0);
        chk("mid_rst_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_pc", redirect_pc, 32'd0);
        chk("mid_rst_stats", stat_branches | stat_taken, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
